trace_scheduler: RTL and testbench
==================================

TRACE_SCHEDULER -- requirements
Module: trace_scheduler

Interface
REQ-001 Parameter ACC_WIDTH, default 32, width of trace inputs and best metric.
REQ-002 Parameter NUM_CAND, default 16, number of candidate G matrices scanned per run (2..256).
REQ-003 Parameter IDX_W, default 4, candidate index width; SHALL satisfy 2^IDX_W >= NUM_CAND.
REQ-004 Parameter TIMEOUT, default 63, maximum WAIT cycles per candidate (used only under REQ-026).
REQ-005 clk  in  1  clock; reset rst, synchronous, active-high; clock clk.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 start  in  1  request a full scan; honoured only in IDLE.
REQ-008 abort  in  1  terminate the scan in progress.
REQ-009 busy  out  1  high in every state except IDLE.
REQ-010 done  out  1  one-cycle pulse: scan complete, results valid.
REQ-011 best_idx  out  IDX_W  index of the winning candidate.
REQ-012 best_metric  out  signed ACC_WIDTH  winning Re{trace}.
REQ-013 err  out  1  sticky: a candidate timed out during the last scan.
REQ-014 cand_sel  out  IDX_W  selects the G_RAM bank for the trace engine; holds the current index.
REQ-015 calc_start  out  1  one-cycle launch pulse to the trace engine.
REQ-016 calc_done  in  1  trace engine completion pulse; trace_r is valid in the same cycle.
REQ-017 trace_r / trace_i  in  signed ACC_WIDTH each  trace result; trace_i is unused.

Function
REQ-018 FSM states: IDLE, LAUNCH, WAIT, COMPARE, FINISH.
- IDLE->LAUNCH on start; idx<=0, err<=0.
- LAUNCH: calc_start=1, ->WAIT.
- WAIT: on calc_done, latch trace_r into cur_metric, ->COMPARE.
- COMPARE: update best, then ->FINISH if idx==NUM_CAND-1, else idx<=idx+1, ->LAUNCH.
- FINISH: done=1, ->IDLE.
REQ-019 Metric rule: update best when idx==0 or cur_metric > best_metric (signed, strict); ties keep the lower index.
REQ-020 best_idx and best_metric change only in COMPARE and hold their values through IDLE until the next scan updates them.
REQ-021 Latency per candidate: 3 + D cycles, where D is cycles from calc_start to calc_done. Total from start accepted to done = NUM_CAND*(3+D)+1.
REQ-022 start outside IDLE is ignored; calc_done outside WAIT is ignored.
REQ-023 abort has priority over every transition except rst: next state IDLE, no done pulse, best_* unchanged from the last completed COMPARE, err held.
REQ-024 start and abort asserted together in IDLE: abort wins; stay in IDLE.

Reset
REQ-025 rst, sampled on clk, SHALL force IDLE, idx=0, cand_sel=0, calc_start=0, done=0, busy=0, best_idx=0, best_metric=0, err=0, cur_metric=0, timeout counter=0; valid mid-scan, and a calc_done in the reset cycle is discarded.

Configuration
REQ-026 Macro TRACE_SCHED_TIMEOUT_EN.
- Defined: a counter clears on entry to WAIT and increments each WAIT cycle. If it reaches TIMEOUT without calc_done: err<=1, the candidate is skipped (no compare), and the FSM proceeds as from COMPARE. calc_done in the same cycle as timeout wins.
- Undefined: WAIT is unbounded, no counter logic exists, and err is tied to 0.

Verification
REQ-027 NUM_CAND=4, D=9, metrics {5,-3,12,7}: start -> calc_start pulses for idx 0..3; done at cycle 4*12+1=49; best_idx=2, best_metric=12.
REQ-028 Metrics {-8,-8,-20,-9}: done -> best_idx=0, best_metric=-8 (tie keeps lower index; all-negative handled signed).
REQ-029 abort during WAIT of idx 2, metrics {1,4,...} -> IDLE next cycle, no done, best_idx=1, best_metric=4; a subsequent start runs a full 4-candidate scan.
REQ-030 rst asserted in COMPARE of idx 1 -> next cycle all outputs at reset values; start is accepted 1 cycle later.
REQ-031 TRACE_SCHED_TIMEOUT_EN, TIMEOUT=15, calc_done withheld for idx 1, metrics {3,x,2,1} -> err=1 and done still pulses; best_idx=0, best_metric=3.
REQ-032 start pulsed while busy, and a spurious calc_done in IDLE -> no state change and no extra calc_start.

Source files
------------

// File: rtl/trace_scheduler.sv
// Sequences a trace engine over NUM_CAND G-matrix candidates and keeps the best Re{trace}.
// Optional per-candidate WAIT watchdog is compiled in with `define TRACE_SCHED_TIMEOUT_EN.
module trace_scheduler #(
  parameter int ACC_WIDTH = 32,
  parameter int NUM_CAND  = 16,
  parameter int IDX_W     = 4,
  parameter int TIMEOUT   = 63
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_i,
  input  logic                        abort_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [IDX_W-1:0]            best_idx_o,
  output logic signed [ACC_WIDTH-1:0] best_metric_o,
  output logic                        err_o,
  output logic [IDX_W-1:0]            cand_sel_o,
  output logic                        calc_start_o,
  input  logic                        calc_done_i,
  input  logic signed [ACC_WIDTH-1:0] trace_r_i,
  input  logic signed [ACC_WIDTH-1:0] trace_i_i
);

  // state   | meaning
  // IDLE    | waiting for start
  // LAUNCH  | pulse calc_start for candidate idx
  // WAIT    | waiting for calc_done from the trace engine
  // COMPARE | fold cur_metric into the running best
  // FINISH  | pulse done, results valid
  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT, S_COMPARE, S_FINISH
  } state_t;

  state_t                        state_q, state_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [IDX_W-1:0]              best_idx_q, best_idx_d;
  logic signed [ACC_WIDTH-1:0]   best_metric_q, best_metric_d;
  logic signed [ACC_WIDTH-1:0]   cur_metric_q, cur_metric_d;
  logic                          last_cand;

`ifdef TRACE_SCHED_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
`endif

  assign last_cand = (idx_q == IDX_W'(NUM_CAND - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      best_idx_q    <= '0;
      best_metric_q <= '0;
      cur_metric_q  <= '0;
`ifdef TRACE_SCHED_TIMEOUT_EN
      tmo_q         <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      best_idx_q    <= best_idx_d;
      best_metric_q <= best_metric_d;
      cur_metric_q  <= cur_metric_d;
`ifdef TRACE_SCHED_TIMEOUT_EN
      tmo_q         <= tmo_d;
      err_q         <= err_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    best_idx_d    = best_idx_q;
    best_metric_d = best_metric_q;
    cur_metric_d  = cur_metric_q;
`ifdef TRACE_SCHED_TIMEOUT_EN
    tmo_d         = tmo_q;
    err_d         = err_q;
`endif
    // Abort freezes every register except the state, so best_* reflect the last COMPARE.
    if (abort_i) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_d = S_LAUNCH;
            idx_d   = '0;
`ifdef TRACE_SCHED_TIMEOUT_EN
            err_d   = 1'b0;
`endif
          end
        end
        S_LAUNCH: begin
          state_d = S_WAIT;
`ifdef TRACE_SCHED_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
        S_WAIT: begin
          if (calc_done_i) begin
            cur_metric_d = trace_r_i;
            state_d      = S_COMPARE;
          end
`ifdef TRACE_SCHED_TIMEOUT_EN
          else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
            err_d = 1'b1;
            if (last_cand) begin
              state_d = S_FINISH;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = S_LAUNCH;
            end
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
`endif
        end
        S_COMPARE: begin
          if ((idx_q == '0) || (cur_metric_q > best_metric_q)) begin
            best_idx_d    = idx_q;
            best_metric_d = cur_metric_q;
          end
          if (last_cand) begin
            state_d = S_FINISH;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_LAUNCH;
          end
        end
        S_FINISH: state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy_o       = (state_q != S_IDLE);
    calc_start_o = (state_q == S_LAUNCH) && !abort_i;
    done_o       = (state_q == S_FINISH) && !abort_i;
  end

  assign cand_sel_o    = idx_q;
  assign best_idx_o    = best_idx_q;
  assign best_metric_o = best_metric_q;

`ifdef TRACE_SCHED_TIMEOUT_EN
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  // The imaginary part of the trace carries no information for the selection.
  logic unused_ok;
  assign unused_ok = ^{trace_i_i, 1'(TIMEOUT)};

endmodule

// File: tb/tb_trace_scheduler.sv
// Directed bench for trace_scheduler with a fixed-latency trace engine model (D = 9).
module tb_trace_scheduler;
  localparam int AW = 32;
  localparam int NC = 4;
  localparam int IW = 2;
  localparam int D  = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic          abort_i = 1'b0;
  logic          busy_o, done_o, err_o, calc_start_o;
  logic [IW-1:0] best_idx_o, cand_sel_o;
  logic signed [AW-1:0] best_metric_o;
  logic          calc_done_i;
  logic signed [AW-1:0] trace_r_i;
  logic signed [AW-1:0] trace_i_i = '0;

  logic signed [AW-1:0] metrics [NC];
  logic          withhold [NC];
  logic          spur_done = 1'b0;
  int            eng_cnt;

  int test_cnt = 0;
  int fail_cnt = 0;

  always #5 clk = ~clk;

  trace_scheduler #(.ACC_WIDTH(AW), .NUM_CAND(NC), .IDX_W(IW), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
    .busy_o(busy_o), .done_o(done_o), .best_idx_o(best_idx_o),
    .best_metric_o(best_metric_o), .err_o(err_o), .cand_sel_o(cand_sel_o),
    .calc_start_o(calc_start_o), .calc_done_i(calc_done_i),
    .trace_r_i(trace_r_i), .trace_i_i(trace_i_i)
  );

  // Engine model: calc_done lands in the 10th WAIT cycle after the calc_start cycle.
  always @(posedge clk) begin
    if (rst)                eng_cnt <= 0;
    else if (calc_start_o)  eng_cnt <= D + 1;
    else if (eng_cnt != 0)  eng_cnt <= eng_cnt - 1;
  end
  assign calc_done_i = ((eng_cnt == 1) && !withhold[cand_sel_o]) || spur_done;
  assign trace_r_i   = metrics[cand_sel_o];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    test_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  task automatic set_metrics(input int m0, input int m1, input int m2, input int m3);
    metrics[0] = m0; metrics[1] = m1; metrics[2] = m2; metrics[3] = m3;
  endtask

  // Starts a scan and returns the cycle index of done (0 if it never came).
  task automatic run_scan(input bit poke_start, output int cyc, output int n_launch);
    @(negedge clk) start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    cyc = 0;
    n_launch = 0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (poke_start) start_i = (n == 5) || (n == 20);
      if (calc_start_o) begin
        chk("launch_sel", 64'(cand_sel_o), 64'(n_launch));
        n_launch++;
      end
      if (done_o) begin
        cyc = n;
        break;
      end
    end
    start_i = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"},   64'(busy_o), 64'(0));
    chk({tag, "_done"},   64'(done_o), 64'(0));
    chk({tag, "_cstart"}, 64'(calc_start_o), 64'(0));
    chk({tag, "_bidx"},   64'(best_idx_o), 64'(0));
    chk({tag, "_bmet"},   best_metric_o, 64'(0));
    chk({tag, "_err"},    64'(err_o), 64'(0));
    chk({tag, "_sel"},    64'(cand_sel_o), 64'(0));
  endtask

  initial begin
    int cyc, nl, dcount;
    bit found;
    for (int i = 0; i < NC; i++) withhold[i] = 1'b0;
    set_metrics(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("rst");

    // Basic scan with a clear winner in the middle
    set_metrics(5, -3, 12, 7);
    run_scan(1'b0, cyc, nl);
    chk("s1_cycles", 64'(cyc), 64'(49));
    chk("s1_launches", 64'(nl), 64'(4));
    chk("s1_bidx", 64'(best_idx_o), 64'(2));
    chk("s1_bmet", best_metric_o, 64'(12));
    chk("s1_err", 64'(err_o), 64'(0));
    @(negedge clk);
    chk("s1_done_pulse", 64'(done_o), 64'(0));
    chk("s1_idle", 64'(busy_o), 64'(0));
    repeat (3) @(negedge clk);
    chk("s1_hold_bidx", 64'(best_idx_o), 64'(2));
    chk("s1_hold_bmet", best_metric_o, 64'(12));

    // Ties keep the lower index; all values negative
    set_metrics(-8, -8, -20, -9);
    run_scan(1'b0, cyc, nl);
    chk("s2_cycles", 64'(cyc), 64'(49));
    chk("s2_bidx", 64'(best_idx_o), 64'(0));
    chk("s2_bmet", best_metric_o, -64'sd8);

    // start pulsed while busy must not disturb the scan
    set_metrics(1, 2, 3, -1);
    run_scan(1'b1, cyc, nl);
    chk("s3_cycles", 64'(cyc), 64'(49));
    chk("s3_launches", 64'(nl), 64'(4));
    chk("s3_bidx", 64'(best_idx_o), 64'(2));
    chk("s3_bmet", best_metric_o, 64'(3));

    // Spurious calc_done in IDLE
    repeat (3) @(negedge clk);
    spur_done = 1'b1;
    @(posedge clk); #1 spur_done = 1'b0;
    @(negedge clk);
    chk("spur_busy", 64'(busy_o), 64'(0));
    chk("spur_cstart", 64'(calc_start_o), 64'(0));
    chk("spur_bmet", best_metric_o, 64'(3));

    // Abort during WAIT of candidate 2
    set_metrics(1, 4, 9, 2);
    @(negedge clk) start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      @(negedge clk);
      if (calc_start_o && cand_sel_o == 2'd2) found = 1'b1;
    end
    chk("ab_found_l2", 64'(found), 64'(1));
    @(negedge clk) abort_i = 1'b1;
    @(posedge clk); #1 abort_i = 1'b0;
    @(negedge clk);
    chk("ab_busy", 64'(busy_o), 64'(0));
    chk("ab_bidx", 64'(best_idx_o), 64'(1));
    chk("ab_bmet", best_metric_o, 64'(4));
    dcount = 0;
    for (int n = 0; n < 15; n++) begin
      if (done_o || busy_o) dcount++;
      @(negedge clk);
    end
    chk("ab_no_done", 64'(dcount), 64'(0));
    run_scan(1'b0, cyc, nl);
    chk("ab_rescan_cycles", 64'(cyc), 64'(49));
    chk("ab_rescan_bidx", 64'(best_idx_o), 64'(2));
    chk("ab_rescan_bmet", best_metric_o, 64'(9));

    // start and abort together in IDLE: abort wins
    @(negedge clk) begin start_i = 1'b1; abort_i = 1'b1; end
    @(posedge clk); #1 begin start_i = 1'b0; abort_i = 1'b0; end
    @(negedge clk);
    chk("sa_busy", 64'(busy_o), 64'(0));
    chk("sa_cstart", 64'(calc_start_o), 64'(0));

    // Reset asserted in COMPARE of candidate 1
    set_metrics(6, 8, 1, 1);
    @(negedge clk) start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      @(negedge clk);
      if (calc_done_i && cand_sel_o == 2'd1) found = 1'b1;
    end
    chk("rc_found_w1", 64'(found), 64'(1));
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("rc");
    start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    @(negedge clk);
    chk("rc_restart_cstart", 64'(calc_start_o), 64'(1));
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      @(negedge clk);
      if (done_o) found = 1'b1;
    end
    chk("rc_done", 64'(found), 64'(1));
    chk("rc_bidx", 64'(best_idx_o), 64'(1));
    chk("rc_bmet", best_metric_o, 64'(8));

`ifdef TRACE_SCHED_TIMEOUT_EN
    // Candidate 1 never answers: 15-cycle WAIT timeout, no compare
    set_metrics(3, 100, 2, 1);
    withhold[1] = 1'b1;
    run_scan(1'b0, cyc, nl);
    withhold[1] = 1'b0;
    chk("to_cycles", 64'(cyc), 64'(53));
    chk("to_err", 64'(err_o), 64'(1));
    chk("to_bidx", 64'(best_idx_o), 64'(0));
    chk("to_bmet", best_metric_o, 64'(3));
`endif

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
